dragon_hit_detect: RTL
======================

Name: dragon_hit_detect

Overview:
- Collision/kill arbiter sitting directly upstream of the dragon mover; it generates the dragon's `life_state` kill request.
- Compares the dragon's top-left position and visibility against one bullet and the player sprite every clk_22 tick.
- Holds the kill request until the dragon acknowledges it by dropping `show_valid`, then re-arms once the dragon respawns.
- Maintains the BCD kill score shown on the seven-segment display.

Parameters:
- DRAGON_W, 40, dragon bounding-box width in pixels
- DRAGON_H, 30, dragon bounding-box height in pixels
- BULLET_W, 4, bullet box width
- BULLET_H, 4, bullet box height
- PLAYER_W, 32, player box width
- PLAYER_H, 32, player box height
- HOLD_MAX, 8, max cycles `life_state` is held without an acknowledge

Ports:
- clk_22  input  1  game tick clock
- rst  input  1  asynchronous active-low reset
- pause  input  1  game paused; gates new detections only
- d_x, d_y  input  10 each  dragon top-left position
- show_valid  input  1  dragon alive/visible
- b_x, b_y  input  10 each  bullet top-left position
- b_valid  input  1  bullet in flight
- p_x, p_y  input  10 each  player top-left position
- life_state  output  1  kill request to dragon, level
- bullet_hit  output  1  one-cycle pulse: bullet consumed by dragon
- player_hit  output  1  one-cycle pulse: dragon touched player
- score  output  16  4-digit BCD kill count, digit 3 in [15:12]
- ack_err  output  1  sticky: kill hold timed out

Behaviour:
- Reset (async, rst=0):
  - FSM=ARMED.
  - life_state, bullet_hit, player_hit, ack_err = 0.
  - score = 16'h0000.
  - Hold counter = 0.
- Overlap test (combinational):
  - Axis-aligned box test, all sums in 11 bits, no wrap.
  - Overlap(A,B) is true when A.x < B.x+B.W, B.x < A.x+A.W, A.y < B.y+B.H and B.y < A.y+A.H.
  - Edge-touching boxes (A.x+A.W == B.x) do not overlap.
- hit_b = show_valid & b_valid & overlap(dragon, bullet).
- hit_p = show_valid & overlap(dragon, player).
- FSM states: ARMED, KILL, WAIT_BACK.
- ARMED:
  - Condition for a kill: pause=0 and (hit_b or hit_p).
  - On the next edge: life_state<=1, hold counter<=0, go to KILL.
  - bullet_hit<=hit_b and player_hit<=hit_p, each for exactly one cycle.
  - If hit_b: score increments by one, BCD with carry, saturating at 9999.
  - hit_b and hit_p together: both pulses fire, score +1 once, single kill.
  - pause=1: no detection and no pulses; stay in ARMED.
- KILL:
  - life_state stays 1 and the hold counter increments each cycle.
  - show_valid==0 → life_state<=0, go to WAIT_BACK.
  - Hold counter reaches HOLD_MAX-1 with show_valid still 1 → life_state<=0, ack_err<=1, go to WAIT_BACK.
  - pause does not affect this state, because the dragon's alive logic runs during pause.
  - No further pulses or score changes.
- WAIT_BACK:
  - life_state=0.
  - show_valid==1 → go to ARMED.
  - Detection becomes possible on the cycle after ARMED is re-entered; it is never evaluated in the same cycle as the transition.
- Pulse outputs are registered and return to 0 on the following cycle.
- ack_err clears only on reset.
- Reset mid-KILL: life_state drops immediately (async); score clears.
- Expected handshake latency with the dragon mover:
  - life_state rises at edge N.
  - show_valid falls at edge N+1.
  - life_state falls at edge N+2.

Test Plan:
- Bullet hit, score increments: d=(300,200), b=(310,210), b_valid=1, show_valid=1 → bullet_hit pulse of 1 cycle, life_state=1, score 0000→0001. Drop show_valid 1 cycle later → life_state=0 next edge, FSM in WAIT_BACK.
- Edge touch, no hit: b=(340,210) with DRAGON_W=40 → no hit. Then b=(339,210) → hit.
- Simultaneous bullet and player hit: p overlaps dragon in the same cycle as a bullet hit → both pulses, score +1 only, single life_state assertion.
- Hit while paused, then unpause: pause=1 with an overlapping bullet → no response. pause=0 → kill on the next edge.
- No acknowledge: show_valid held at 1 after a kill → life_state high for exactly 8 cycles, then 0; ack_err=1 and stays 1. Re-arm only after show_valid is seen 1 in WAIT_BACK.
- Score saturation and reset: preload score via 9999 hits → stays 9999 after the next hit. Assert rst mid-KILL → life_state=0 and score=0000 immediately.

Source files
------------

// File: rtl/dragon_hit_detect.sv
// ============================================================================
// dragon_hit_detect : bullet/player collision arbiter and BCD kill score
// Revision 1.0
// ============================================================================
`default_nettype none

module dragon_hit_detect #(
  parameter int unsigned DRAGON_W = 40,
  parameter int unsigned DRAGON_H = 30,
  parameter int unsigned BULLET_W = 4,
  parameter int unsigned BULLET_H = 4,
  parameter int unsigned PLAYER_W = 32,
  parameter int unsigned PLAYER_H = 32,
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic        clk_22,
  input  logic        rst,
  input  logic        pause,
  input  logic [9:0]  d_x,
  input  logic [9:0]  d_y,
  input  logic        show_valid,
  input  logic [9:0]  b_x,
  input  logic [9:0]  b_y,
  input  logic        b_valid,
  input  logic [9:0]  p_x,
  input  logic [9:0]  p_y,
  output logic        life_state,
  output logic        bullet_hit,
  output logic        player_hit,
  output logic [15:0] score,
  output logic        ack_err
);

  localparam int unsigned CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  localparam logic [10:0]      c_DRAGON_W = 11'(DRAGON_W);
  localparam logic [10:0]      c_DRAGON_H = 11'(DRAGON_H);
  localparam logic [10:0]      c_BULLET_W = 11'(BULLET_W);
  localparam logic [10:0]      c_BULLET_H = 11'(BULLET_H);
  localparam logic [10:0]      c_PLAYER_W = 11'(PLAYER_W);
  localparam logic [10:0]      c_PLAYER_H = 11'(PLAYER_H);
  localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  typedef enum logic [1:0] {
    ARMED     = 2'd0,
    KILL      = 2'd1,
    WAIT_BACK = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_hold, w_hold_nxt;
  logic               r_life, r_bhit, r_phit, r_err;
  logic [15:0]        r_score;
  logic               w_bhit_nxt, w_phit_nxt, w_err_nxt;
  logic [15:0]        w_score_nxt;

  // Strict comparisons so that edge-touching boxes never count as overlap.
  function automatic logic overlap(
    input logic [9:0]  ax, input logic [9:0] ay, input logic [10:0] aw, input logic [10:0] ah,
    input logic [9:0]  bx, input logic [9:0] by, input logic [10:0] bw, input logic [10:0] bh
  );
    return ({1'b0, ax} < ({1'b0, bx} + bw)) && ({1'b0, bx} < ({1'b0, ax} + aw)) &&
           ({1'b0, ay} < ({1'b0, by} + bh)) && ({1'b0, by} < ({1'b0, ay} + ah));
  endfunction

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] res;
    logic        carry;
    res   = v;
    carry = 1'b1;
    if (v == 16'h9999) return v;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (res[i*4 +: 4] == 4'd9) begin
          res[i*4 +: 4] = 4'd0;
        end else begin
          res[i*4 +: 4] = res[i*4 +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
    return res;
  endfunction

  logic w_hit_b, w_hit_p;

  assign w_hit_b = show_valid & b_valid &
                   overlap(d_x, d_y, c_DRAGON_W, c_DRAGON_H, b_x, b_y, c_BULLET_W, c_BULLET_H);
  assign w_hit_p = show_valid &
                   overlap(d_x, d_y, c_DRAGON_W, c_DRAGON_H, p_x, p_y, c_PLAYER_W, c_PLAYER_H);

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_bhit_nxt  = 1'b0;
    w_phit_nxt  = 1'b0;
    w_err_nxt   = r_err;
    w_score_nxt = r_score;
    case (r_state)
      ARMED: begin
        if (!pause && (w_hit_b || w_hit_p)) begin
          w_state_nxt = KILL;
          w_hold_nxt  = '0;
          w_bhit_nxt  = w_hit_b;
          w_phit_nxt  = w_hit_p;
          if (w_hit_b) w_score_nxt = bcd_inc(r_score);
        end
      end
      KILL: begin
        // Acknowledge takes priority over the timeout on the same cycle.
        if (!show_valid) begin
          w_state_nxt = WAIT_BACK;
        end else if (r_hold == c_HOLD_LAST) begin
          w_state_nxt = WAIT_BACK;
          w_err_nxt   = 1'b1;
        end else begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end
      WAIT_BACK: begin
        if (show_valid) w_state_nxt = ARMED;
      end
      default: w_state_nxt = ARMED;
    endcase
  end

  always_ff @(posedge clk_22 or negedge rst) begin
    if (!rst) begin
      r_state <= ARMED;
      r_hold  <= '0;
      r_life  <= 1'b0;
      r_bhit  <= 1'b0;
      r_phit  <= 1'b0;
      r_err   <= 1'b0;
      r_score <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_life  <= (w_state_nxt == KILL);
      r_bhit  <= w_bhit_nxt;
      r_phit  <= w_phit_nxt;
      r_err   <= w_err_nxt;
      r_score <= w_score_nxt;
    end
  end

  assign life_state = r_life;
  assign bullet_hit = r_bhit;
  assign player_hit = r_phit;
  assign score      = r_score;
  assign ack_err    = r_err;

endmodule

`default_nettype wire
